// File: rtl/painterengine_gpu_writer_arbiter.sv
// Round-robin arbiter that shares the single GPU cache writer between up to four pixel producers.
// Latches the winner's address/length, muxes its cache bus, and owns the writer handshake and watchdog.
module painterengine_gpu_writer_arbiter #(
  parameter int PARAM_REQUESTERS     = 4,
  parameter int PARAM_ADDRESS_WIDTH  = 32,
  parameter int PARAM_DATA_WIDTH     = 32,
  parameter int PARAM_CACHE_MAX_SIZE = 256,
  parameter int PARAM_TIMEOUT        = 65535
) (
  input  logic                                                               i_wire_axi_clock,
  input  logic                                                               i_wire_resetn,
  input  logic [PARAM_REQUESTERS-1:0]                                        i_wire_req_enable,
  input  logic [PARAM_REQUESTERS*PARAM_ADDRESS_WIDTH-1:0]                    i_wire_req_address,
  input  logic [PARAM_REQUESTERS*9-1:0]                                      i_wire_req_length,
  input  logic [PARAM_REQUESTERS*PARAM_DATA_WIDTH*PARAM_CACHE_MAX_SIZE-1:0]  i_wire_req_cache,
  output logic [PARAM_REQUESTERS-1:0]                                        o_wire_req_done,
  output logic [PARAM_REQUESTERS-1:0]                                        o_wire_req_error,
  output logic [PARAM_REQUESTERS-1:0]                                        o_wire_grant,
  output logic [PARAM_ADDRESS_WIDTH-1:0]                                     o_wire_cache_address,
  output logic [8:0]                                                         o_wire_cache_length,
  output logic [PARAM_DATA_WIDTH*PARAM_CACHE_MAX_SIZE-1:0]                   o_wire_cache,
  output logic                                                               o_wire_writer_enable,
  input  logic                                                               i_wire_writer_done,
  output logic                                                               o_wire_busy
);

  localparam int N  = PARAM_REQUESTERS;
  localparam int AW = PARAM_ADDRESS_WIDTH;
  localparam int CW = PARAM_DATA_WIDTH * PARAM_CACHE_MAX_SIZE;
  localparam int LW = 9;
  localparam int IW = $clog2(N);

  localparam logic [IW-1:0] LAST_INDEX    = IW'(N - 1);
  localparam logic [9:0]    MAX_LENGTH    = 10'(PARAM_CACHE_MAX_SIZE);
  localparam logic [15:0]   TIMEOUT_LIMIT = 16'(PARAM_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    grant_q, grant_d;
  logic [IW-1:0]   grant_idx_q, grant_idx_d;
  logic [IW-1:0]   last_grant_q, last_grant_d;
  logic [AW-1:0]   address_q, address_d;
  logic [LW-1:0]   length_q, length_d;
  logic [N-1:0]    done_q, done_d;
  logic [N-1:0]    error_q, error_d;
  logic            enable_q, enable_d;
  logic [15:0]     watchdog_q, watchdog_d;

  logic            found;
  logic [IW-1:0]   pick;
  logic [N-1:0]    pick_onehot;
  logic [AW-1:0]   sel_address;
  logic [LW-1:0]   sel_length;
  logic            length_ok;
  logic [16:0]     watchdog_inc;
  logic [15:0]     watchdog_sat;
  logic            timeout_hit;

  // Round-robin scan: the requester right after the last one served has top priority.
  always_comb begin
    int cand;
    found = 1'b0;
    pick  = last_grant_q;
    cand  = 0;
    for (int i = 1; i <= N; i++) begin
      cand = int'(last_grant_q) + i;
      if (cand >= N) cand = cand - N;
      for (int k = 0; k < N; k++) begin
        if (!found && cand == k && i_wire_req_enable[k]) begin
          found = 1'b1;
          pick  = IW'(k);
        end
      end
    end
  end

  always_comb begin
    sel_address = '0;
    sel_length  = '0;
    for (int k = 0; k < N; k++) begin
      if (pick == IW'(k)) begin
        sel_address = i_wire_req_address[AW*k +: AW];
        sel_length  = i_wire_req_length[LW*k +: LW];
      end
    end
  end

  assign pick_onehot  = N'(1) << pick;
  assign length_ok    = (sel_length != '0) && ({1'b0, sel_length} <= MAX_LENGTH);
  assign watchdog_inc = {1'b0, watchdog_q} + 17'd1;
  assign watchdog_sat = watchdog_inc[16] ? 16'hFFFF : watchdog_inc[15:0];
  assign timeout_hit  = (watchdog_sat >= TIMEOUT_LIMIT);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    address_d    = address_q;
    length_d     = length_q;
    done_d       = '0;
    error_d      = '0;
    enable_d     = enable_q;
    watchdog_d   = watchdog_q;

    case (state_q)
      IDLE: begin
        grant_d  = '0;
        enable_d = 1'b0;
        if (found) begin
          address_d   = sel_address;
          length_d    = sel_length;
          grant_idx_d = pick;
          grant_d     = pick_onehot;
          if (!length_ok) begin
            // Unservable length: answer immediately and never touch the writer.
            done_d       = pick_onehot;
            error_d      = pick_onehot;
            last_grant_d = pick;
          end else begin
            enable_d   = 1'b1;
            watchdog_d = '0;
            state_d    = WRITE;
          end
        end
      end

      WRITE: begin
        watchdog_d = watchdog_sat;
        if (i_wire_writer_done) begin
          enable_d     = 1'b0;
          done_d       = grant_q;
          grant_d      = '0;
          last_grant_d = grant_idx_q;
          state_d      = RELEASE;
        end else if (timeout_hit) begin
          enable_d     = 1'b0;
          done_d       = grant_q;
          error_d      = grant_q;
          grant_d      = '0;
          last_grant_d = grant_idx_q;
          state_d      = RELEASE;
        end
      end

      // A writer that holds done for several cycles must not complete the next transfer.
      RELEASE: begin
        if (!i_wire_writer_done) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_wire_axi_clock) begin
    if (!i_wire_resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      grant_idx_q  <= '0;
      last_grant_q <= LAST_INDEX;
      address_q    <= '0;
      length_q     <= '0;
      done_q       <= '0;
      error_q      <= '0;
      enable_q     <= 1'b0;
      watchdog_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      address_q    <= address_d;
      length_q     <= length_d;
      done_q       <= done_d;
      error_q      <= error_d;
      enable_q     <= enable_d;
      watchdog_q   <= watchdog_d;
    end
  end

  always_comb begin
    o_wire_cache = '0;
    for (int k = 0; k < N; k++) begin
      if (grant_q[k]) o_wire_cache = o_wire_cache | i_wire_req_cache[CW*k +: CW];
    end
  end

  assign o_wire_req_done      = done_q;
  assign o_wire_req_error     = error_q;
  assign o_wire_grant         = grant_q;
  assign o_wire_cache_address = address_q;
  assign o_wire_cache_length  = length_q;
  assign o_wire_writer_enable = enable_q;
  assign o_wire_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_painterengine_gpu_writer_arbiter.sv
// Scoreboard bench for the GPU writer arbiter: requests are queued in expected service order
// and matched against grant/done activity, with a small writer model answering the enable.
module tb_painterengine_gpu_writer_arbiter;

  localparam int N       = 4;
  localparam int AW      = 32;
  localparam int DW      = 8;
  localparam int CMS     = 256;
  localparam int TIMEOUT = 16;
  localparam int CW      = DW * CMS;

  typedef struct {
    int               idx;
    logic [AW-1:0]    addr;
    logic [8:0]       len;
    bit               badLen;
    bit               timeout;
    int               expCycles;
    int               issued;
  } entry_t;

  logic                clock;
  logic                resetn;
  logic [N-1:0]        reqEnable;
  logic [N*AW-1:0]     reqAddress;
  logic [N*9-1:0]      reqLength;
  logic [N*CW-1:0]     reqCache;
  logic [N-1:0]        reqDone;
  logic [N-1:0]        reqError;
  logic [N-1:0]        grant;
  logic [AW-1:0]       cacheAddress;
  logic [8:0]          cacheLength;
  logic [CW-1:0]       cacheBus;
  logic                writerEnable;
  logic                writerDone;
  logic                busy;

  entry_t sb[$];
  int     checks = 0;
  int     errors = 0;
  int     cycleNow = 0;
  int     writerDelay = 3;
  int     writerHold = 1;
  bit     writerMute = 0;
  int     wrCount = 0;
  int     holdCount = 0;
  int     rearm[N];
  int     enableCycles = 0;
  logic   prevEnable = 1'b0;

  painterengine_gpu_writer_arbiter #(
    .PARAM_REQUESTERS(N),
    .PARAM_ADDRESS_WIDTH(AW),
    .PARAM_DATA_WIDTH(DW),
    .PARAM_CACHE_MAX_SIZE(CMS),
    .PARAM_TIMEOUT(TIMEOUT)
  ) dut (
    .i_wire_axi_clock(clock),
    .i_wire_resetn(resetn),
    .i_wire_req_enable(reqEnable),
    .i_wire_req_address(reqAddress),
    .i_wire_req_length(reqLength),
    .i_wire_req_cache(reqCache),
    .o_wire_req_done(reqDone),
    .o_wire_req_error(reqError),
    .o_wire_grant(grant),
    .o_wire_cache_address(cacheAddress),
    .o_wire_cache_length(cacheLength),
    .o_wire_cache(cacheBus),
    .o_wire_writer_enable(writerEnable),
    .i_wire_writer_done(writerDone),
    .o_wire_busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] pixel(input int k, input int p);
    return DW'(k * 37 + p * 3 + 1);
  endfunction

  function automatic logic [63:0] cacheLow(input int k);
    logic [63:0] r;
    r = '0;
    for (int p = 0; p < 8; p++) r[p*8 +: 8] = pixel(k, p);
    return r;
  endfunction

  function automatic logic [63:0] cacheHigh(input int k);
    logic [63:0] r;
    r = '0;
    for (int p = 0; p < 8; p++) r[p*8 +: 8] = pixel(k, CMS - 8 + p);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Matches grant starts and done pulses against the head of the scoreboard.
  task automatic monitor();
    entry_t e;
    if (writerEnable && !prevEnable) begin
      enableCycles = 0;
      if (sb.size() == 0) begin
        checkOutput("unexpected grant", 64'(grant), 64'd0);
      end else begin
        e = sb[0];
        checkOutput("grant", 64'(grant), 64'(1) << e.idx);
        checkOutput("address", 64'(cacheAddress), 64'(e.addr));
        checkOutput("length", 64'(cacheLength), 64'(e.len));
        checkOutput("cache low", cacheBus[63:0], cacheLow(e.idx));
        checkOutput("cache high", cacheBus[CW-1 -: 64], cacheHigh(e.idx));
        checkOutput("enable on bad length", 64'(e.badLen), 64'd0);
        checkOutput("writer done low at grant", 64'(writerDone), 64'd0);
      end
    end
    if (writerEnable) enableCycles++;
    prevEnable = writerEnable;
    if (reqDone != '0 || reqError != '0) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected done", 64'({reqDone, reqError}), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("done", 64'(reqDone), 64'(1) << e.idx);
        checkOutput("error", 64'(reqError), (e.badLen || e.timeout) ? (64'(1) << e.idx) : 64'd0);
        checkOutput("enable cycles", 64'(enableCycles), 64'(e.expCycles));
        checkOutput("enable low at done", 64'(writerEnable), 64'd0);
        if (e.badLen) checkOutput("bad length latency", 64'(cycleNow - e.issued), 64'd1);
        enableCycles = 0;
        if (rearm[e.idx] > 0) begin
          rearm[e.idx]--;
          e.issued = cycleNow;
          sb.push_back(e);
        end else begin
          reqEnable[e.idx] = 1'b0;
        end
      end
    end
  endtask

  task automatic writerModel();
    if (writerDone) begin
      holdCount--;
      if (holdCount <= 0) writerDone = 1'b0;
    end else if (writerEnable && !writerMute) begin
      wrCount++;
      if (wrCount >= writerDelay) begin
        writerDone = 1'b1;
        holdCount  = writerHold;
        wrCount    = 0;
      end
    end else begin
      wrCount = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cycleNow++;
    monitor();
    writerModel();
  endtask

  task automatic applyStimulus(input int k, input logic [AW-1:0] addr, input logic [8:0] len);
    entry_t e;
    reqAddress[AW*k +: AW] = addr;
    reqLength[9*k +: 9]    = len;
    reqEnable[k]           = 1'b1;
    e.idx       = k;
    e.addr      = addr;
    e.len       = len;
    e.badLen    = (len == 9'd0) || (int'(len) > CMS);
    e.timeout   = !e.badLen && writerMute;
    e.expCycles = e.badLen ? 0 : (writerMute ? TIMEOUT : writerDelay);
    e.issued    = cycleNow;
    sb.push_back(e);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " grant"}, 64'(grant), 64'd0);
    checkOutput({tag, " enable"}, 64'(writerEnable), 64'd0);
    checkOutput({tag, " busy"}, 64'(busy), 64'd0);
    checkOutput({tag, " done"}, 64'(reqDone), 64'd0);
    checkOutput({tag, " error"}, 64'(reqError), 64'd0);
    checkOutput({tag, " address"}, 64'(cacheAddress), 64'd0);
    checkOutput({tag, " length"}, 64'(cacheLength), 64'd0);
  endtask

  task automatic doReset();
    resetn     = 1'b0;
    reqEnable  = '0;
    writerDone = 1'b0;
    writerMute = 1'b0;
    wrCount    = 0;
    holdCount  = 0;
    for (int k = 0; k < N; k++) rearm[k] = 0;
    sb.delete();
    tick();
    tick();
    resetn       = 1'b1;
    enableCycles = 0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n;
    n = 0;
    while ((sb.size() > 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    checkOutput({"drain ", tag}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n;
    resetn     = 1'b0;
    reqEnable  = '0;
    reqAddress = '0;
    reqLength  = '0;
    writerDone = 1'b0;
    reqCache   = '0;
    for (int k = 0; k < N; k++)
      for (int p = 0; p < CMS; p++)
        reqCache[CW*k + DW*p +: DW] = pixel(k, p);

    doReset();
    checkResetValues("reset");

    // Single requester, one-cycle writer done.
    writerDelay = 3;
    writerHold  = 1;
    applyStimulus(0, 32'h1000, 9'd64);
    tick();
    checkOutput("first grant", 64'(grant), 64'h1);
    checkOutput("first enable", 64'(writerEnable), 64'h1);
    n = 0;
    while (sb.size() > 0 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("first drained", 64'(sb.size()), 64'd0);
    tick();
    checkOutput("busy after release", 64'(busy), 64'd0);
    checkOutput("cache zero when idle", cacheBus[63:0], 64'd0);

    // All four pending; requester 0 keeps requesting and comes back last.
    doReset();
    rearm[0] = 1;
    for (int k = 0; k < N; k++) applyStimulus(k, 32'h2000 + 32'(k) * 32'h100, 9'(16 + k));
    waitIdle("round robin", 200);

    // Length boundaries on requester 2.
    doReset();
    applyStimulus(2, 32'h3000, 9'd0);
    waitIdle("length 0", 20);
    applyStimulus(2, 32'h3100, 9'd257);
    waitIdle("length 257", 20);
    applyStimulus(2, 32'h3200, 9'd256);
    waitIdle("length 256", 40);

    // Writer holds done for five cycles while requester 1 waits.
    doReset();
    writerDelay = 2;
    writerHold  = 5;
    applyStimulus(0, 32'h4000, 9'd32);
    applyStimulus(1, 32'h4100, 9'd48);
    waitIdle("held done", 100);
    writerDelay = 3;
    writerHold  = 1;

    // Silent writer trips the watchdog, then arbitration carries on.
    doReset();
    writerMute = 1'b1;
    applyStimulus(0, 32'h5000, 9'd100);
    waitIdle("timeout", 60);
    writerMute = 1'b0;
    applyStimulus(1, 32'h5100, 9'd8);
    waitIdle("after timeout", 30);

    // Reset in the middle of a write.
    doReset();
    writerMute = 1'b1;
    applyStimulus(0, 32'h6000, 9'd20);
    n = 0;
    while (!writerEnable && n < 10) begin
      tick();
      n++;
    end
    checkOutput("enable before mid reset", 64'(writerEnable), 64'h1);
    tick();
    resetn = 1'b0;
    tick();
    checkResetValues("mid reset");
    sb.delete();
    reqEnable  = '0;
    writerMute = 1'b0;
    tick();
    checkOutput("no done during reset", 64'({reqDone, reqError}), 64'd0);
    resetn       = 1'b1;
    enableCycles = 0;
    applyStimulus(0, 32'h7000, 9'd10);
    applyStimulus(2, 32'h7200, 9'd12);
    waitIdle("after mid reset", 60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not finish");
  end

endmodule
